// File: rtl/gol_pkg.sv
// Shared constants for the board seeder: default geometry, FSM encoding,
// LFSR taps and the substitute seed used when a zero seed is requested.
package gol_pkg;

  localparam int S_SIZE = 1024;
  localparam int CNT_W  = 12;

  localparam logic [15:0] DEF_SEED = 16'hACE1;

  localparam int LFSR_TAP0 = 15;
  localparam int LFSR_TAP1 = 13;
  localparam int LFSR_TAP2 = 12;
  localparam int LFSR_TAP3 = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } seed_state_e;

  // Fibonacci form (x^16+x^14+x^13+x^11+1), maximal length 65535.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[LFSR_TAP0] ^ l[LFSR_TAP1] ^ l[LFSR_TAP2] ^ l[LFSR_TAP3]};
  endfunction

endpackage

// File: rtl/board_seeder_if.sv
// Request/status bundle of the board seeder.
// The abort input exists only when BOARD_SEEDER_ABORT_EN is defined.
interface board_seeder_if #(
  parameter int S_SIZE = gol_pkg::S_SIZE,
  parameter int CNT_W  = gol_pkg::CNT_W
);

  logic              start;
  logic [CNT_W-1:0]  target;
  logic [15:0]       seed;
`ifdef BOARD_SEEDER_ABORT_EN
  logic              abort;
`endif
  logic [S_SIZE-1:0] state;
  logic [CNT_W-1:0]  placed;
  logic              busy;
  logic              done;

  modport master (
`ifdef BOARD_SEEDER_ABORT_EN
    output abort,
`endif
    output start, target, seed,
    input  state, placed, busy, done
  );

  modport slave (
`ifdef BOARD_SEEDER_ABORT_EN
    input  abort,
`endif
    input  start, target, seed,
    output state, placed, busy, done
  );

endinterface

// File: rtl/gol_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; load wins over step.
module gol_lfsr16
  import gol_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst)       value <= DEF_SEED;
    else if (load) value <= load_val;
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/board_seeder.sv
// Seeds a board with a target number of alive cells at LFSR-chosen positions.
// Optional abort input enabled by defining BOARD_SEEDER_ABORT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; board and placed hold last result
// FILL  | one LFSR index per cycle; empty cell is set, full cell retried
// DONE  | one-cycle done pulse, then back to IDLE
module board_seeder #(
  parameter int S_SIZE = gol_pkg::S_SIZE,
  parameter int CNT_W  = gol_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  board_seeder_if.slave bus
);
  import gol_pkg::*;

  localparam int IDX_W = $clog2(S_SIZE);

  seed_state_e       fsm_q, fsm_d;
  logic [S_SIZE-1:0] board_q;
  logic [CNT_W-1:0]  placed_q;
  logic [CNT_W-1:0]  tgt_q;
  logic [CNT_W-1:0]  tgt_clamped;
  logic [15:0]       seed_eff;
  logic [15:0]       lfsr_val;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              place;
  logic              abort_req;
  logic              lfsr_unused;

  assign idx         = lfsr_val[IDX_W-1:0];
  assign lfsr_unused = ^lfsr_val[15:IDX_W];
  assign tgt_clamped = (int'(bus.target) > S_SIZE) ? CNT_W'(S_SIZE) : bus.target;
  assign seed_eff    = (bus.seed == 16'h0000) ? DEF_SEED : bus.seed;

`ifdef BOARD_SEEDER_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  gol_lfsr16 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (seed_eff),
    .step     (fsm_q == ST_FILL),
    .value    (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d    = fsm_q;
    accept   = 1'b0;
    place    = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          fsm_d  = (tgt_clamped == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        bus.busy = 1'b1;
        place    = ~board_q[idx];
        // An abort in the same cycle as a placement still keeps that cell.
        if (abort_req || (place && (placed_q + CNT_W'(1) == tgt_q)))
          fsm_d = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        fsm_d    = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board_q  <= '0;
      placed_q <= '0;
      tgt_q    <= '0;
    end else if (accept) begin
      board_q  <= '0;
      placed_q <= '0;
      tgt_q    <= tgt_clamped;
    end else if (place) begin
      board_q[idx] <= 1'b1;
      placed_q     <= placed_q + CNT_W'(1);
    end
  end

  assign bus.state  = board_q;
  assign bus.placed = placed_q;

endmodule

// File: tb/tb_board_seeder.sv
// Self-checking bench for board_seeder: table vectors, random runs and
// hand-written reset/abort sequences against a cycle-level array model.
module tb_board_seeder;

  localparam int S  = 1024;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_seeder_if #(.S_SIZE(S), .CNT_W(CW)) bus ();

  board_seeder #(.S_SIZE(S), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int model_step(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 32'hFFFF;
  endfunction

  // exp_placed < 0 means "whatever the model reached" (abort runs).
  task automatic run_seed(input string tag, input int tgt, input logic [15:0] sd,
                          input int exp_placed, input int poke_at, input bit poke_done,
                          input int abort_at);
    bit [S-1:0] mb;
    int mcnt, clamp, l, i, trace_err, idx, held;
    bit fin;
    mb        = '0;
    mcnt      = 0;
    trace_err = 0;
    clamp     = (tgt > S) ? S : tgt;
    l         = (sd == 16'h0000) ? 32'hACE1 : int'(sd);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = CW'(tgt);
    bus.seed   = sd;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.target = CW'($urandom);
    bus.seed   = 16'($urandom);
    fin = (clamp == 0);
    i   = 0;
    while (!fin) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.placed !== CW'(mcnt)) trace_err++;
      if (i == poke_at) begin
        bus.start  = 1'b1;
        bus.target = CW'(3);
      end
      if (i == poke_at + 1) bus.start = 1'b0;
      idx = l % S;
      if (!mb[idx]) begin
        mb[idx] = 1'b1;
        mcnt++;
      end
      if (mcnt == clamp) fin = 1'b1;
      if (i == abort_at) begin
`ifdef BOARD_SEEDER_ABORT_EN
        bus.abort = 1'b1;
`endif
        fin = 1'b1;
      end
      l = model_step(l);
      i++;
      if (i > 70000) begin
        chk({tag, "_timeout"}, 64'(i), 64'd65535);
        fin = 1'b1;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
`ifdef BOARD_SEEDER_ABORT_EN
    bus.abort = 1'b0;
`endif
    chk({tag, "_trace_err"}, 64'(trace_err), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, "_placed"}, 64'(bus.placed), (exp_placed < 0) ? 64'(mcnt) : 64'(exp_placed));
    chk({tag, "_board_pop"}, 64'($countones(bus.state)), 64'($countones(mb)));
    chk({tag, "_board_eq"}, 64'(bus.state === mb), 64'd1);
    held = mcnt;
    if (poke_done) begin
      bus.start  = 1'b1;
      bus.target = CW'(5);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_pulse_end"}, 64'(bus.done), 64'd0);
    if (poke_done) begin
      @(negedge clk);
      chk({tag, "_start_in_done_ignored"}, 64'(bus.busy), 64'd0);
      chk({tag, "_placed_hold"}, 64'(bus.placed), 64'(held));
    end
  endtask

  typedef struct {
    int         tgt;
    logic [15:0] seed;
    int         exp_placed;
    int         poke_at;
    bit         poke_done;
  } vec_t;

  vec_t vecs[6];
  int   seen_done;
  int   rt;

  initial begin
    vecs[0] = '{tgt: 1,    seed: 16'h0001, exp_placed: 1,    poke_at: -1, poke_done: 1'b0};
    vecs[1] = '{tgt: 0,    seed: 16'h1234, exp_placed: 0,    poke_at: -1, poke_done: 1'b0};
    vecs[2] = '{tgt: 5,    seed: 16'h0000, exp_placed: 5,    poke_at: -1, poke_done: 1'b1};
    vecs[3] = '{tgt: 37,   seed: 16'hBEEF, exp_placed: 37,   poke_at: -1, poke_done: 1'b0};
    vecs[4] = '{tgt: 10,   seed: 16'h4321, exp_placed: 10,   poke_at: 2,  poke_done: 1'b0};
    vecs[5] = '{tgt: 4095, seed: 16'h5A5A, exp_placed: 1024, poke_at: -1, poke_done: 1'b0};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.target = '0;
    bus.seed   = '0;
`ifdef BOARD_SEEDER_ABORT_EN
    bus.abort  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_placed", 64'(bus.placed), 64'd0);
    chk("rst_board_pop", 64'($countones(bus.state)), 64'd0);

    // Reset outranks a simultaneous start.
    bus.start  = 1'b1;
    bus.target = CW'(7);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    chk("rst_over_start_busy", 64'(bus.busy), 64'd0);
    chk("rst_over_start_done", 64'(bus.done), 64'd0);

    foreach (vecs[k])
      run_seed($sformatf("vec%0d", k), vecs[k].tgt, vecs[k].seed, vecs[k].exp_placed,
               vecs[k].poke_at, vecs[k].poke_done, -1);

    for (int r = 0; r < 6; r++) begin
      rt = int'($urandom_range(1, 200));
      run_seed($sformatf("rnd%0d", r), rt, 16'($urandom), rt, -1, 1'b0, -1);
    end

    // Reset in the middle of a fill abandons it silently.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = CW'(500);
    bus.seed   = 16'h7777;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    chk("midfill_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_placed", 64'(bus.placed), 64'd0);
    chk("midrst_board_pop", 64'($countones(bus.state)), 64'd0);
    seen_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    chk("midrst_stays_idle", 64'(seen_done), 64'd0);
    run_seed("after_rst", 20, 16'h7777, 20, -1, 1'b0, -1);

`ifdef BOARD_SEEDER_ABORT_EN
    run_seed("abort", 800, 16'h2468, -1, -1, 1'b0, 100);
    chk("abort_pop_eq_placed", 64'($countones(bus.state)), 64'(bus.placed));
    chk("abort_below_target", 64'(int'(bus.placed) < 800), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_seeder.md
BOARD_SEEDER -- requirements
Module: board_seeder

Interface
REQ-001 The block SHALL expose parameter S_SIZE, default 1024, the number of board cells; a power of two in 2..2048.
REQ-002 The block SHALL expose parameter CNT_W, default 12, the width of the count ports.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle request to seed a new board; sampled only in IDLE.
REQ-007 target  input  CNT_W  number of alive cells to place; latched on accepted start.
REQ-008 seed  input  16  LFSR seed; latched on accepted start.
REQ-009 state  output  S_SIZE  generated board, one bit per cell, 1 = alive.
REQ-010 placed  output  CNT_W  alive cells placed so far.
REQ-011 busy  output  1  high while in FILL.
REQ-012 done  output  1  one-cycle pulse when seeding completes.

Function
REQ-013 The FSM SHALL have three states: IDLE, FILL and DONE.
REQ-014 IDLE + start on an edge: state<=0, placed<=0, target latched and clamped to S_SIZE, LFSR<=seed (seed 0 replaced by 16'hACE1); next state FILL, or DONE if the clamped target is 0.
REQ-015 LFSR: 16-bit Fibonacci, shifts left, new bit0 = l[15]^l[13]^l[12]^l[10]; it SHALL step every FILL cycle.
REQ-016 FILL cell index = current (pre-step) LFSR[IDX_W-1:0], where IDX_W = clog2(S_SIZE).
REQ-017 FILL, indexed cell 0: set it and increment placed.
REQ-018 FILL, indexed cell 1: no change to state or placed (collision; retried on later cycles).
REQ-019 FILL SHALL go to DONE on the edge where placed reaches the latched target.
REQ-020 Seeding SHALL take at most 65535 FILL cycles, because the LFSR period covers every index.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; state and placed hold until the next accepted start.
REQ-022 Latency for target 1: start in cycle 0, cell set in cycle 1, done in cycle 2.
REQ-023 start while in FILL or DONE SHALL be ignored; there is no queuing.
REQ-024 placed SHALL never exceed the latched target; no wrap-around is possible.

Reset
REQ-025 rst high SHALL force IDLE, state=0, placed=0, busy=0, done=0, LFSR=16'hACE1, target=0.
REQ-026 rst in any state, including mid-FILL, takes effect at the next edge and abandons seeding; no done pulse is issued.
REQ-027 rst takes priority over start and abort.

Configuration
REQ-028 Macro BOARD_SEEDER_ABORT_EN SHALL control the abort feature.
REQ-029 With BOARD_SEEDER_ABORT_EN defined: extra input abort (1 bit); abort high in FILL goes to DONE on the next edge, retaining placed and state.
REQ-030 With BOARD_SEEDER_ABORT_EN defined: abort SHALL be ignored in IDLE and DONE, and abort and placing in the same cycle still sets that cell.
REQ-031 Without BOARD_SEEDER_ABORT_EN: no abort port; FILL exits only by reaching target or by rst.

Structure
REQ-032 Shared package gol_pkg SHALL hold S_SIZE, CNT_W, the FSM state encoding typedef, LFSR tap constants and the default seed 16'hACE1.
REQ-033 Sub-module gol_lfsr16 SHALL implement the LFSR, with ports clk, rst, load, load_val, step, value; board_seeder instantiates one.

Verification
REQ-034 start, target=1, seed=16'h0001: cycle 1 sets state[1]; cycle 2 done=1 with placed=1 and only bit 1 set.
REQ-035 start, target=0: done the cycle after start, state all zero, placed=0, busy never high.
REQ-036 start, target=4095, S_SIZE=1024: target clamps to 1024; all bits 1 and placed=1024 within 65536 cycles; every collision cycle leaves placed unchanged.
REQ-037 rst pulsed mid-FILL with target=500: next cycle IDLE, state=0, placed=0, no done; a subsequent start reseeds correctly.
REQ-038 start asserted again during FILL with a different target: ignored; completion uses the first target.
REQ-039 With BOARD_SEEDER_ABORT_EN, target=800, abort after 100 FILL cycles: done the following cycle, placed equals popcount(state), and placed < 800.
